// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared opcode constants, register sizes and the decoded register-use record
package hazard_pkg;

  localparam int REG_W    = 3;
  localparam int NUM_REGS = 8;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam reg_idx_t LINK_REG = reg_idx_t'(7);

  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_BTR   = 5'b11001;
  localparam logic [4:0] OP_ALU_A = 5'b11010;
  localparam logic [4:0] OP_ALU_B = 5'b11011;

  // Opcode groups identified by their top three bits.
  localparam logic [2:0] OPG_IMM_A = 3'b010;
  localparam logic [2:0] OPG_BR    = 3'b011;
  localparam logic [2:0] OPG_IMM_B = 3'b101;
  localparam logic [2:0] OPG_ALU3  = 3'b111;

  typedef struct packed {
    reg_idx_t src1;
    logic     src1_v;
    reg_idx_t src2;
    logic     src2_v;
    reg_idx_t dest;
    logic     dest_v;
  } reg_use_t;

endpackage

// File: rtl/inst_reg_decode.sv
// rtl/inst_reg_decode.sv - combinational map from a 16-bit instruction to its source/destination registers
module inst_reg_decode
  import hazard_pkg::*;
(
  input  logic [15:0] i_inst,
  output reg_use_t    o_use
);

  logic [4:0] w_op;
  logic [2:0] w_grp;
  reg_idx_t   w_rs;
  reg_idx_t   w_rt;
  reg_idx_t   w_rd;
  logic       w_unused;

  assign w_op     = i_inst[15:11];
  assign w_grp    = i_inst[15:13];
  assign w_rs     = i_inst[10:8];
  assign w_rt     = i_inst[7:5];
  assign w_rd     = i_inst[4:2];
  assign w_unused = &{1'b0, i_inst[1:0]};

  // Unused fields stay at zero with their valid flag low so downstream compares never see X.
  always_comb begin
    o_use = '0;
    if (w_op == OP_ALU_A || w_op == OP_ALU_B || w_grp == OPG_ALU3) begin
      o_use.src1 = w_rs; o_use.src1_v = 1'b1;
      o_use.src2 = w_rt; o_use.src2_v = 1'b1;
      o_use.dest = w_rd; o_use.dest_v = 1'b1;
    end else if (w_op == OP_BTR) begin
      o_use.src1 = w_rs; o_use.src1_v = 1'b1;
      o_use.dest = w_rd; o_use.dest_v = 1'b1;
    end else if (w_grp == OPG_IMM_A || w_grp == OPG_IMM_B || w_op == OP_LD) begin
      o_use.src1 = w_rs; o_use.src1_v = 1'b1;
      o_use.dest = w_rt; o_use.dest_v = 1'b1;
    end else if (w_op == OP_ST) begin
      o_use.src1 = w_rs; o_use.src1_v = 1'b1;
      o_use.src2 = w_rt; o_use.src2_v = 1'b1;
    end else if (w_op == OP_STU) begin
      o_use.src1 = w_rs; o_use.src1_v = 1'b1;
      o_use.src2 = w_rt; o_use.src2_v = 1'b1;
      o_use.dest = w_rs; o_use.dest_v = 1'b1;
    end else if (w_op == OP_LBI) begin
      o_use.dest = w_rs; o_use.dest_v = 1'b1;
    end else if (w_op == OP_SLBI) begin
      o_use.src1 = w_rs; o_use.src1_v = 1'b1;
      o_use.dest = w_rs; o_use.dest_v = 1'b1;
    end else if (w_op == OP_JR || w_grp == OPG_BR) begin
      o_use.src1 = w_rs; o_use.src1_v = 1'b1;
    end else if (w_op == OP_JALR) begin
      o_use.src1 = w_rs;     o_use.src1_v = 1'b1;
      o_use.dest = LINK_REG; o_use.dest_v = 1'b1;
    end else if (w_op == OP_JAL) begin
      o_use.dest = LINK_REG; o_use.dest_v = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage register scoreboard with RAW stall, busy vector and stall counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [15:0]   i_id_inst,
  input  logic          i_id_valid,
  input  logic          i_hold,
  input  logic          i_flush,
  output logic          o_stall,
  output logic [7:0]    o_busy_vec,
  output logic [15:0]   o_stall_count
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(WB_LAT);

  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic [CNT_W-1:0]    w_cnt_nxt [NUM_REGS];
  logic [15:0]         r_stall_count;
  logic [NUM_REGS-1:0] w_busy;
  reg_use_t            w_use;
  logic                w_src_hit;
  logic                w_stall;
  logic                w_issue;

  inst_reg_decode u_decode (
    .i_inst (i_id_inst),
    .o_use  (w_use)
  );

  always_comb begin
    w_busy = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
    end
  end

  // Hazard check reads the pre-update counts, so an instruction never stalls on its own write.
  assign w_src_hit = (w_use.src1_v & w_busy[w_use.src1]) |
                     (w_use.src2_v & w_busy[w_use.src2]);
  assign w_stall   = i_id_valid & ~i_rst & w_src_hit;
  assign w_issue   = i_id_valid & ~w_stall & ~i_hold & ~i_flush & w_use.dest_v;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt[i] = (r_cnt[i] != '0) ? r_cnt[i] - 1'b1 : '0;
      if (i_flush) begin
        if (r_cnt[i] == LAT) begin
          w_cnt_nxt[i] = '0;
        end
      end else if (w_issue && w_use.dest == reg_idx_t'(i)) begin
        w_cnt_nxt[i] = LAT;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (!i_hold) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_count <= '0;
    end else if (w_stall && !i_hold && r_stall_count != 16'hFFFF) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign o_stall       = w_stall;
  assign o_busy_vec    = w_busy;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and randomized bench for hazard_scoreboard against a ready-time model
module tb_hazard_scoreboard;

  localparam int LAT = 3;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [15:0] i_id_inst = '0;
  logic        i_id_valid = 1'b0;
  logic        i_hold = 1'b0;
  logic        i_flush = 1'b0;
  logic        o_stall;
  logic [7:0]  o_busy_vec;
  logic [15:0] o_stall_count;

  int checks = 0;
  int errors = 0;

  // Model: time advances only on non-held edges; a register is busy while ready[r] > t.
  int t;
  int ready [8];
  int issued_at [8];
  int scnt;

  logic       seen_stall;
  logic [7:0] seen_busy;

  hazard_scoreboard #(.WB_LAT(LAT), .CNT_W(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_id_inst     (i_id_inst),
    .i_id_valid    (i_id_valid),
    .i_hold        (i_hold),
    .i_flush       (i_flush),
    .o_stall       (o_stall),
    .o_busy_vec    (o_busy_vec),
    .o_stall_count (o_stall_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [4:0] op, input int a, input int b, input int c);
    logic [2:0] fa, fb, fc;
    fa = a[2:0]; fb = b[2:0]; fc = c[2:0];
    return {op, fa, fb, fc, 2'b00};
  endfunction

  function automatic void ref_decode(input logic [15:0] ins, output logic [7:0] srcm,
                                     output bit dv, output int d);
    logic [4:0] op;
    int rs, rt, rd;
    op = ins[15:11];
    rs = int'(ins[10:8]); rt = int'(ins[7:5]); rd = int'(ins[4:2]);
    srcm = '0; dv = 0; d = 0;
    if (op == 5'b11010 || op == 5'b11011 || op[4:2] == 3'b111) begin
      srcm[rs] = 1; srcm[rt] = 1; dv = 1; d = rd;
    end else if (op == 5'b11001) begin
      srcm[rs] = 1; dv = 1; d = rd;
    end else if (op[4:2] == 3'b010 || op[4:2] == 3'b101 || op == 5'b10001) begin
      srcm[rs] = 1; dv = 1; d = rt;
    end else if (op == 5'b10000) begin
      srcm[rs] = 1; srcm[rt] = 1;
    end else if (op == 5'b10011) begin
      srcm[rs] = 1; srcm[rt] = 1; dv = 1; d = rs;
    end else if (op == 5'b11000) begin
      dv = 1; d = rs;
    end else if (op == 5'b10010) begin
      srcm[rs] = 1; dv = 1; d = rs;
    end else if (op == 5'b00101 || op[4:2] == 3'b011) begin
      srcm[rs] = 1;
    end else if (op == 5'b00111) begin
      srcm[rs] = 1; dv = 1; d = 7;
    end else if (op == 5'b00110) begin
      dv = 1; d = 7;
    end
  endfunction

  function automatic logic [7:0] model_busy();
    logic [7:0] b;
    for (int r = 0; r < 8; r++) b[r] = (ready[r] > t);
    return b;
  endfunction

  task automatic model_reset();
    t = 0; scnt = 0;
    for (int r = 0; r < 8; r++) begin
      ready[r] = 0; issued_at[r] = -100;
    end
  endtask

  task automatic step(input logic [15:0] ins, input bit v, input bit h, input bit f);
    logic [7:0] srcm, eb;
    bit dv, es;
    int d;
    i_id_inst = ins; i_id_valid = v; i_hold = h; i_flush = f;
    #2;
    ref_decode(ins, srcm, dv, d);
    eb = model_busy();
    es = v && ((srcm & eb) != 0);
    seen_stall = o_stall;
    seen_busy  = o_busy_vec;
    check("stall", o_stall, es);
    check("busy_vec", o_busy_vec, eb);
    check("stall_count", o_stall_count, scnt);
    @(posedge i_clk);
    if (!h) begin
      if (es && scnt < 65535) scnt++;
      if (f) begin
        for (int r = 0; r < 8; r++) begin
          if (issued_at[r] == t - 1) begin
            ready[r] = 0; issued_at[r] = -100;
          end
        end
      end else if (v && !es && dv) begin
        ready[d] = t + 1 + LAT; issued_at[d] = t;
      end
      t++;
    end
    #1;
  endtask

  task automatic run_until_issue(input logic [15:0] ins, output int n, output logic [7:0] first_busy);
    n = 0;
    first_busy = '0;
    for (int k = 0; k < 10; k++) begin
      step(ins, 1, 0, 0);
      if (k == 0) first_busy = seen_busy;
      if (!seen_stall) break;
      n++;
    end
  endtask

  task automatic idle();
    repeat (4) step(enc(5'b00001, 0, 0, 0), 1, 0, 0);
  endtask

  task automatic reset_pulse();
    #2;
    i_rst = 1'b1;
    #1;
    check("rst_stall", o_stall, 0);
    check("rst_busy", o_busy_vec, 0);
    check("rst_count", o_stall_count, 0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int frozen;
    logic [7:0] fb;
    logic [15:0] rd3;
    rd3 = enc(5'b11011, 3, 0, 4);
    model_reset();
    i_id_inst = rd3; i_id_valid = 1'b1;
    #1 i_rst = 1'b1;
    #2;
    check("reset_stall", o_stall, 0);
    check("reset_busy", o_busy_vec, 0);
    check("reset_count", o_stall_count, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    step(enc(5'b11011, 1, 2, 3), 1, 0, 0);
    run_until_issue(rd3, n, fb);
    check("raw_stalls", n, 3);
    check("raw_busy", fb, 8'h08);
    check("raw_after_busy", seen_busy, 8'h00);
    idle();

    step(enc(5'b00110, 0, 0, 0), 1, 0, 0);
    run_until_issue(enc(5'b00101, 7, 0, 0), n, fb);
    check("jr7_stalls", n, 3);
    check("jr7_busy7", fb[7], 1);
    idle();
    step(enc(5'b00110, 0, 0, 0), 1, 0, 0);
    run_until_issue(enc(5'b00101, 6, 0, 0), n, fb);
    check("jr6_stalls", n, 0);
    idle();

    step(enc(5'b11000, 2, 5, 1), 1, 0, 0);
    run_until_issue(enc(5'b10000, 1, 2, 0), n, fb);
    check("st_rt_stalls", n, 3);
    idle();
    step(enc(5'b11000, 4, 5, 1), 1, 0, 0);
    run_until_issue(enc(5'b10000, 1, 2, 0), n, fb);
    check("st_free_stalls", n, 0);
    idle();

    step(enc(5'b01000, 1, 5, 0), 1, 0, 0);
    step(enc(5'b00001, 0, 0, 0), 1, 0, 1);
    run_until_issue(enc(5'b01000, 5, 6, 0), n, fb);
    check("flush_clear_stalls", n, 0);
    idle();
    step(enc(5'b01000, 1, 4, 0), 1, 0, 0);
    step(enc(5'b00001, 0, 0, 0), 1, 0, 0);
    step(enc(5'b00001, 0, 0, 0), 1, 0, 1);
    run_until_issue(enc(5'b01000, 4, 6, 0), n, fb);
    check("flush_old_stalls", n, 1);
    idle();

    step(enc(5'b11011, 1, 2, 3), 1, 0, 0);
    step(rd3, 1, 0, 0);
    frozen = int'(o_stall_count);
    repeat (4) begin
      step(rd3, 1, 1, 0);
      check("hold_stall", seen_stall, 1);
      check("hold_busy", seen_busy, 8'h08);
    end
    check("hold_count", o_stall_count, frozen);
    run_until_issue(rd3, n, fb);
    check("hold_resume_stalls", n, 2);
    idle();

    step(enc(5'b11011, 1, 2, 3), 1, 0, 0);
    step(rd3, 1, 0, 0);
    check("pre_rst_busy", o_busy_vec, 8'h08);
    i_id_inst = rd3; i_id_valid = 1'b1; i_hold = 1'b0; i_flush = 1'b0;
    reset_pulse();
    run_until_issue(rd3, n, fb);
    check("post_rst_stalls", n, 0);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 999) < 4) begin
        reset_pulse();
      end else begin
        step(16'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 11) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
